frame_scan_ctrl: RTL and testbench
==================================

Name: frame_scan_ctrl

Overview:
Downstream consumer of the pixel generator's stream (x, y, 6-bit colour, done). It writes each on-screen pixel into an external synchronous dual-port frame RAM and independently raster-scans that RAM. The scan produces display timing (hsync, vsync, data-enable) plus aligned 6-bit RGB for the 400x225 panel. Pixel clock equals i_clk.

Parameters:
H_ACTIVE, 400, visible pixels per line
H_FP, 8, horizontal front porch, cycles
H_SYNC, 32, hsync pulse width, cycles
H_BP, 40, horizontal back porch, cycles
V_ACTIVE, 225, visible lines per frame
V_FP, 3, vertical front porch, lines
V_SYNC, 5, vsync pulse width, lines
V_BP, 6, vertical back porch, lines
SYNC_POL, 0, sync active level (0 = active-low)
ADDR_W, 17, frame RAM address width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_x  in  9  generator x coordinate
i_y  in  8  generator y coordinate
i_data  in  6  generator pixel colour
i_fill_done  in  1  generator has completed one full frame
o_wr_en  out  1  frame RAM write strobe
o_wr_addr  out  ADDR_W  frame RAM write address
o_wr_data  out  6  frame RAM write data
o_rd_addr  out  ADDR_W  frame RAM read address
i_rd_data  in  6  frame RAM read data, one cycle after o_rd_addr
o_hsync  out  1  horizontal sync
o_vsync  out  1  vertical sync
o_de  out  1  active-video enable
o_rgb  out  6  pixel colour; 0 when o_de low
o_frame_start  out  1  one-cycle pulse with first active pixel of frame

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk.
- Reset values: o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_rd_addr 0, o_de 0, o_rgb 0, o_frame_start 0. o_hsync and o_vsync are at the inactive level (= !SYNC_POL).
- Write path, 1-cycle registered latency:
  - o_wr_en = (i_x < H_ACTIVE) & (i_y < V_ACTIVE).
  - o_wr_addr = i_y*400 + i_x. Compute with shifts/adds ((y<<8)+(y<<7)+(y<<4)+x); no multiplier.
  - o_wr_data = i_data.
  - Out-of-range coordinates give o_wr_en 0. Address and data are then don't-care but deterministic.
- Scan enable:
  - Internal scan_en is cleared by reset and set on the first cycle i_fill_done is 1. It stays set until reset; a later low i_fill_done is ignored.
  - While scan_en is 0: counters hold at 0, o_rd_addr holds 0, syncs are inactive, o_de 0, o_rgb 0.
- Counters:
  - h_cnt runs 0..H_total-1, where H_total = H_ACTIVE+H_FP+H_SYNC+H_BP = 480. It wraps to 0 and then v_cnt increments.
  - v_cnt runs 0..V_total-1 = 238 and wraps to 0.
  - Frame length is 480*239 = 114720 cycles.
- Regions at counter stage:
  - active = h_cnt<400 & v_cnt<225.
  - hsync asserted for h_cnt in 408..439.
  - vsync asserted for v_cnt in 228..232, over whole lines.
- Read address: registered (stage 1).
  - Increments by 1 for each active counter cycle.
  - Reset to 0 when h_cnt=0 and v_cnt=0.
  - Holds during blanking, giving 0..89999 per frame.
- Output alignment: o_hsync, o_vsync, o_de and o_frame_start are delayed 2 cycles from the counter stage. o_rgb is registered from i_rd_data when delayed-de is 1, else 0. All outputs are therefore mutually aligned.
- o_frame_start: 1 when the delayed position is h=0, v=0.
- Read/write to the same address in the same cycle: no bypass. New data appears on a later frame.
- Reset mid-frame returns all state to reset values within 1 cycle. scan_en clears, and scanning restarts only after the next i_fill_done.

Test Plan:
- Write mapping: (x=0,y=0,d=6'h2A) -> next cycle o_wr_en=1, addr 0, data 2A. (399,224) -> addr 89999. (400,10) -> o_wr_en=0. (5,225) -> o_wr_en=0.
- Pre-fill hold: i_fill_done=0 for 1000 cycles -> o_de=0, syncs inactive (1), o_rd_addr=0 throughout. Pulse i_fill_done once -> scanning starts and continues after it drops.
- Line timing: after enable, o_de high for 400 consecutive cycles, then low 80. o_hsync low for exactly 32 cycles, starting 408 cycles after o_de rose. Period 480.
- Frame timing: o_vsync low for 5*480=2400 cycles per 114720-cycle frame. o_frame_start pulses once per frame, coincident with first o_de rise of line 0.
- Read addressing/data: RAM model returns addr[5:0]. o_rd_addr steps 0..399 on line 0 and 400..799 on line 1; o_rgb at active pixel n equals n[5:0]; o_rgb=0 in blanking.
- Reset mid-frame: assert i_rst at v_cnt=100 -> next cycle all outputs at reset values. Re-enable via i_fill_done -> first o_frame_start exactly 2 cycles after enable cycle's counters start at (0,0).

Source files
------------

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl
// Receives the pixel generator's stream and writes each on-screen pixel
// into an external synchronous dual-port frame RAM. Separately, it
// raster-scans that RAM to drive the 400x225 panel with hsync, vsync,
// data-enable and RGB. The pixel clock is i_clk.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_x, i_y, i_data    generator coordinate and 6-bit colour
//   i_fill_done         generator finished a frame; starts scanning
//   o_wr_en/addr/data   frame RAM write port (1-cycle registered)
//   o_rd_addr           frame RAM read address
//   i_rd_data           frame RAM read data, one cycle after o_rd_addr
//   o_hsync, o_vsync    sync outputs, active level SYNC_POL
//   o_de, o_rgb         active-video enable and colour (0 outside active)
//   o_frame_start       pulse with the first active pixel of each frame
//
// Scan pipeline
//   stage 0: h_cnt/v_cnt and o_rd_addr are aligned. o_rd_addr is the
//            pixel index at the current counter position.
//   stage 1: region flags registered, RAM data arrives
//   stage 2: outputs registered (syncs, de, rgb, frame_start)
//
// state        | meaning
// ST_WAIT_FILL | no complete frame in RAM yet; counters and outputs idle
// ST_SCAN      | free-running raster scan until reset

module frame_scan_ctrl #(
    parameter int   H_ACTIVE = 400,
    parameter int   H_FP     = 8,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 40,
    parameter int   V_ACTIVE = 225,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 6,
    parameter logic SYNC_POL = 1'b0,
    parameter int   ADDR_W   = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [8:0]        i_x,
    input  logic [7:0]        i_y,
    input  logic [5:0]        i_data,
    input  logic              i_fill_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [5:0]        o_wr_data,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [5:0]        i_rd_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [5:0]        o_rgb,
    output logic              o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;

    assign wr_en_nxt = (i_x < 9'(H_ACTIVE)) && (i_y < 8'(V_ACTIVE));

    // y*400 as (y<<8)+(y<<7)+(y<<4). The RAM row pitch is fixed at 400.
    assign wr_addr_nxt = ADDR_W'({i_y, 8'd0}) + ADDR_W'({i_y, 7'd0})
                       + ADDR_W'({i_y, 4'd0}) + ADDR_W'(i_x);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en   <= wr_en_nxt;
            o_wr_addr <= wr_addr_nxt;
            o_wr_data <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Scan path
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_WAIT_FILL = 1'b0,
        ST_SCAN      = 1'b1
    } state_t;

    state_t     state;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       scan_en;
    logic       act_nxt;
    logic       in_act;
    logic       in_hs;
    logic       in_vs;
    logic       at_origin;
    logic       de_d1;
    logic       hs_d1;
    logic       vs_d1;
    logic       fs_d1;

    assign scan_en = (state == ST_SCAN);

    assign h_wrap = (h_cnt == H_LAST);
    assign h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    assign v_nxt  = h_wrap ? ((v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1) : v_cnt;

    // o_rd_addr is loaded from the next counter position so that it
    // lines up with h_cnt/v_cnt. The RAM then returns data in stage 1.
    assign act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);

    // The counters rest at (0,0) before scanning, so region flags are
    // qualified by scan_en to keep the idle outputs quiet.
    assign in_act    = scan_en && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign in_hs     = scan_en && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign in_vs     = scan_en && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign at_origin = scan_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_WAIT_FILL;
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_rd_addr     <= '0;
            de_d1         <= 1'b0;
            hs_d1         <= 1'b0;
            vs_d1         <= 1'b0;
            fs_d1         <= 1'b0;
            o_de          <= 1'b0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_rgb         <= '0;
            o_frame_start <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_FILL: begin
                    if (i_fill_done) begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    h_cnt <= h_nxt;
                    v_cnt <= v_nxt;
                    if ((h_nxt == 10'd0) && (v_nxt == 10'd0)) begin
                        o_rd_addr <= '0;
                    end else if (act_nxt) begin
                        o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    end
                end
                default: state <= ST_WAIT_FILL;
            endcase

            de_d1 <= in_act;
            hs_d1 <= in_hs;
            vs_d1 <= in_vs;
            fs_d1 <= at_origin;

            o_de          <= de_d1;
            o_hsync       <= hs_d1 ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= vs_d1 ? SYNC_POL : ~SYNC_POL;
            o_rgb         <= de_d1 ? i_rd_data : 6'd0;
            o_frame_start <= fs_d1;
        end
    end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
module tb_frame_scan_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [8:0]  i_x = '0;
    logic [7:0]  i_y = '0;
    logic [5:0]  i_data = '0;
    logic        i_fill_done = 1'b0;

    // instance a: panel geometry; instance b: short frame (8 lines)
    logic        wr_en_a, wr_en_b;
    logic [16:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
    logic [5:0]  wr_data_a, wr_data_b, rgb_a, rgb_b;
    logic [5:0]  ram_a = '0, ram_b = '0;
    logic        hs_a, hs_b, vs_a, vs_b, de_a, de_b, fs_a, fs_b;

    int errors = 0;
    int checks = 0;
    int scan_n = -1;

    always #5 clk = ~clk;

    // frame RAM models: each location reads back its own address[5:0]
    always @(posedge clk) begin
        ram_a <= rd_addr_a[5:0];
        ram_b <= rd_addr_b[5:0];
    end

    frame_scan_ctrl u_dut_a (
        .i_clk(clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_data(i_data),
        .i_fill_done(i_fill_done), .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a),
        .o_wr_data(wr_data_a), .o_rd_addr(rd_addr_a), .i_rd_data(ram_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a), .o_rgb(rgb_a),
        .o_frame_start(fs_a)
    );

    frame_scan_ctrl #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_dut_b (
        .i_clk(clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_data(i_data),
        .i_fill_done(i_fill_done), .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b),
        .o_wr_data(wr_data_b), .o_rd_addr(rd_addr_b), .i_rd_data(ram_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b), .o_rgb(rgb_b),
        .o_frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (scan_n=%0d)", tag, obs, exp, scan_n);
        end
    endtask

    // Write port expectation from the previous cycle's inputs.
    task automatic chk_wr(input string pfx, input int va, input logic rst,
                          input logic [8:0] x, input logic [7:0] y, input logic [5:0] d,
                          input logic en, input logic [16:0] addr, input logic [5:0] data);
        logic exp_en;
        exp_en = !rst && (int'(x) < 400) && (int'(y) < va);
        chk({pfx, "wr_en"}, 32'(en), 32'(exp_en));
        if (rst) begin
            chk({pfx, "wr_addr"}, 32'(addr), 32'd0);
            chk({pfx, "wr_data"}, 32'(data), 32'd0);
        end else if (exp_en) begin
            chk({pfx, "wr_addr"}, 32'(addr), 32'(int'(y) * 400 + int'(x)));
            chk({pfx, "wr_data"}, 32'(data), 32'(d));
        end
    endtask

    // Raster reference: n is cycles since the first scanning cycle.
    // Counter position is n mod frame; outputs lag it by 2 cycles.
    task automatic chk_scan(input string pfx, input int n, input int va, input int vtot,
                            input int vs0, input int vsw,
                            input logic [16:0] rd, input logic de, input logic hs,
                            input logic vs, input logic fs, input logic [5:0] rgb);
        int frame, q, h, v, e_rd, e_rgb;
        logic e_de, e_hs, e_vs, e_fs;
        frame = 480 * vtot;
        e_rd = 0; e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = 0;
        if (n >= 0) begin
            q = n % frame; h = q % 480; v = q / 480;
            if (v < va) e_rd = v * 400 + ((h < 400) ? h : 399);
            else        e_rd = va * 400 - 1;
        end
        if (n >= 2) begin
            q = (n - 2) % frame; h = q % 480; v = q / 480;
            e_de  = (h < 400) && (v < va);
            e_hs  = !((h >= 408) && (h <= 439));
            e_vs  = !((v >= vs0) && (v < vs0 + vsw));
            e_fs  = (h == 0) && (v == 0);
            e_rgb = e_de ? ((v * 400 + h) % 64) : 0;
        end
        chk({pfx, "rd_addr"}, 32'(rd), 32'(e_rd));
        chk({pfx, "de"}, 32'(de), 32'(e_de));
        chk({pfx, "hsync"}, 32'(hs), 32'(e_hs));
        chk({pfx, "vsync"}, 32'(vs), 32'(e_vs));
        chk({pfx, "frame_start"}, 32'(fs), 32'(e_fs));
        chk({pfx, "rgb"}, 32'(rgb), 32'(e_rgb));
    endtask

    task automatic step(input logic [8:0] x, input logic [7:0] y, input logic [5:0] d,
                        input logic fd, input logic rst);
        i_x = x; i_y = y; i_data = d; i_fill_done = fd; i_rst = rst;
        @(negedge clk);
        if (rst)              scan_n = -1;
        else if (scan_n >= 0) scan_n++;
        else if (fd)          scan_n = 0;
        chk_wr("a.", 225, rst, x, y, d, wr_en_a, wr_addr_a, wr_data_a);
        chk_wr("b.", 4,   rst, x, y, d, wr_en_b, wr_addr_b, wr_data_b);
        chk_scan("a.", scan_n, 225, 239, 228, 5, rd_addr_a, de_a, hs_a, vs_a, fs_a, rgb_a);
        chk_scan("b.", scan_n, 4,   8,   5,   2, rd_addr_b, de_b, hs_b, vs_b, fs_b, rgb_b);
    endtask

    task automatic rstep(input logic fd, input logic rst);
        step(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
             6'($urandom_range(0, 63)), fd, rst);
    endtask

    initial begin
        @(negedge clk);
        step(9'd0, 8'd0, 6'd0, 1'b0, 1'b1);
        step(9'd0, 8'd0, 6'd0, 1'b0, 1'b1);

        // write mapping, including range boundaries
        step(9'd0,   8'd0,   6'h2A, 1'b0, 1'b0);
        step(9'd399, 8'd224, 6'h15, 1'b0, 1'b0);
        step(9'd400, 8'd10,  6'h3F, 1'b0, 1'b0);
        step(9'd5,   8'd225, 6'h01, 1'b0, 1'b0);
        step(9'd399, 8'd3,   6'h22, 1'b0, 1'b0);
        step(9'd0,   8'd4,   6'h11, 1'b0, 1'b0);
        step(9'd511, 8'd255, 6'h33, 1'b0, 1'b0);

        // idle before the first fill_done
        repeat (1000) rstep(1'b0, 1'b0);

        // single enable, then fill_done toggles randomly and must be ignored
        rstep(1'b1, 1'b0);
        while (scan_n < 100 * 480 + 37) rstep(1'($urandom_range(0, 1)), 1'b0);

        // reset mid-frame at line 100
        rstep(1'b0, 1'b1);
        repeat (200) rstep(1'b0, 1'b0);

        // re-enable: scanning restarts from (0,0)
        rstep(1'b1, 1'b0);
        repeat (3 * 480 + 20) rstep(1'($urandom_range(0, 1)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
